frame_sequencer: RTL and testbench

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

---
 rtl/frame_sequencer.sv | 135 +++++++++++++
 tb/tb_frame_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// Raster frame sequencer: runs frame_num frames of h_total x v_total pixels, with hd/vd valid strobes.
// Build option FSEQ_CONT_EN: frame_num_i=0 means continuous frames until stop_i.
module frame_sequencer #(
  parameter int H_W   = 16,
  parameter int V_W   = 13,
  parameter int FRM_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [FRM_W-1:0] frame_num_i,
  input  logic [H_W-1:0]   h_total_i,
  input  logic [H_W-1:0]   h_blank_i,
  input  logic [V_W-1:0]   v_total_i,
  input  logic [V_W-1:0]   v_blank_i,
  output logic             hd_o,
  output logic             vd_o,
  output logic             busy_o,
  output logic             frame_done_o,
  output logic             seq_done_o,
  output logic             cfg_err_o
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [H_W-1:0]   H_ONE   = H_W'(1);
  localparam logic [H_W-1:0]   H_TWO   = H_W'(2);
  localparam logic [V_W-1:0]   V_ONE   = V_W'(1);
  localparam logic [FRM_W-1:0] FRM_ONE = FRM_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [H_W-1:0]   r_hcnt, r_h_total, r_h_blank;
  logic [V_W-1:0]   r_vcnt, r_v_total, r_v_blank;
  logic [FRM_W-1:0] r_frm_rem;
  logic             r_stop_pend;
  logic             r_frame_done, r_seq_done, r_cfg_err;

  logic             w_frm_ok, w_cont, w_cfg_ok;
  logic             w_start_req, w_start_acc, w_cfg_bad;
  logic             w_line_end, w_frame_end, w_last, w_seq_end;
  logic [FRM_W-1:0] w_rem_dec;

`ifdef FSEQ_CONT_EN
  logic r_cont;
  assign w_frm_ok = 1'b1;
  assign w_cont   = r_cont;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_cont <= 1'b0;
    else if (w_start_acc) r_cont <= (frame_num_i == '0);
  end
`else
  assign w_frm_ok = (frame_num_i != '0);
  assign w_cont   = 1'b0;
`endif

  assign w_cfg_ok = (h_total_i >= H_TWO) && (h_blank_i < h_total_i) &&
                    (v_total_i != '0) && (v_blank_i < v_total_i) && w_frm_ok;

  // The seq_done cycle is already IDLE, but a start there must not be taken.
  assign w_start_req = (r_state == S_IDLE) && start_i && !r_seq_done;
  assign w_start_acc = w_start_req && w_cfg_ok;
  assign w_cfg_bad   = w_start_req && !w_cfg_ok;

  assign w_line_end  = (r_hcnt == r_h_total - H_ONE);
  assign w_frame_end = (r_state == S_RUN) && w_line_end && (r_vcnt == r_v_total - V_ONE);
  assign w_rem_dec   = r_frm_rem - FRM_ONE;
  assign w_last      = !w_cont && (w_rem_dec == '0);
  assign w_seq_end   = w_frame_end && (w_last || r_stop_pend || stop_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_acc) w_state_nxt = S_RUN;
      S_RUN:   if (w_seq_end)   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcnt       <= '0;
      r_vcnt       <= '0;
      r_h_total    <= '0;
      r_h_blank    <= '0;
      r_v_total    <= '0;
      r_v_blank    <= '0;
      r_frm_rem    <= '0;
      r_stop_pend  <= 1'b0;
      r_frame_done <= 1'b0;
      r_seq_done   <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_frame_done <= w_frame_end;
      r_seq_done   <= w_seq_end;
      r_cfg_err    <= w_cfg_bad;
      if (w_start_acc) begin
        r_h_total   <= h_total_i;
        r_h_blank   <= h_blank_i;
        r_v_total   <= v_total_i;
        r_v_blank   <= v_blank_i;
        r_frm_rem   <= frame_num_i;
        r_hcnt      <= '0;
        r_vcnt      <= '0;
        r_stop_pend <= 1'b0;
      end else if (r_state == S_RUN) begin
        if (stop_i) r_stop_pend <= 1'b1;
        if (w_line_end) begin
          r_hcnt <= '0;
          r_vcnt <= (r_vcnt == r_v_total - V_ONE) ? '0 : r_vcnt + V_ONE;
        end else begin
          r_hcnt <= r_hcnt + H_ONE;
        end
        if (w_frame_end && !w_cont) r_frm_rem <= w_rem_dec;
        // Leaving RUN: counters have just wrapped to 0, drop the pending stop.
        if (w_seq_end) r_stop_pend <= 1'b0;
      end
    end
  end

  assign busy_o       = (r_state == S_RUN);
  assign hd_o         = busy_o && (r_hcnt >= r_h_blank);
  assign vd_o         = busy_o && (r_vcnt >= r_v_blank);
  assign frame_done_o = r_frame_done;
  assign seq_done_o   = r_seq_done;
  assign cfg_err_o    = r_cfg_err;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed self-checking bench for frame_sequencer.
module tb_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i, stop_i;
  logic [7:0]  frame_num_i;
  logic [15:0] h_total_i, h_blank_i;
  logic [12:0] v_total_i, v_blank_i;
  logic        hd_o, vd_o, busy_o, frame_done_o, seq_done_o, cfg_err_o;

  int checks = 0;
  int failures = 0;
  int busy_cnt, hd_cnt, vd_cnt, fd_cnt, sd_cnt, ce_cnt;
  int fd_first, fd_last, sd_at;
  int first_hd, first_vd, first_busy;
  logic [7:0] busy_vec, sd_vec;

  frame_sequencer #(.H_W(16), .V_W(13), .FRM_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .stop_i(stop_i),
    .frame_num_i(frame_num_i), .h_total_i(h_total_i), .h_blank_i(h_blank_i),
    .v_total_i(v_total_i), .v_blank_i(v_blank_i),
    .hd_o(hd_o), .vd_o(vd_o), .busy_o(busy_o),
    .frame_done_o(frame_done_o), .seq_done_o(seq_done_o), .cfg_err_o(cfg_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int ht, input int hb, input int vt, input int vb, input int fn);
    h_total_i   = 16'(ht);
    h_blank_i   = 16'(hb);
    v_total_i   = 13'(vt);
    v_blank_i   = 13'(vb);
    frame_num_i = 8'(fn);
  endtask

  // Present start for one edge; returns in the first cycle after that edge.
  task automatic do_start();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  // Observe n cycles from the current one (index 0); stop_i pulses at index stop_at.
  task automatic observe(input int n, input int stop_at);
    busy_cnt = 0; hd_cnt = 0; vd_cnt = 0; fd_cnt = 0; sd_cnt = 0; ce_cnt = 0;
    fd_first = -1; fd_last = -1; sd_at = -1;
    first_hd = 0; first_vd = 0; first_busy = 0;
    for (int i = 0; i < n; i++) begin
      stop_i = (i == stop_at);
      if (i == 0) begin
        first_hd = int'(hd_o); first_vd = int'(vd_o); first_busy = int'(busy_o);
      end
      busy_cnt += int'(busy_o);
      hd_cnt   += int'(hd_o);
      vd_cnt   += int'(vd_o);
      ce_cnt   += int'(cfg_err_o);
      if (frame_done_o) begin
        fd_cnt++;
        if (fd_first < 0) fd_first = i;
        fd_last = i;
      end
      if (seq_done_o) begin
        sd_cnt++;
        sd_at = i;
      end
      step();
    end
    stop_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; stop_i = 1'b0;
    set_cfg(8, 2, 4, 1, 2);
    #3;
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_outs", int'({hd_o, vd_o, frame_done_o, seq_done_o, cfg_err_o}), 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Two-frame sequence
    do_start();
    observe(80, -1);
    chk("seq2_first_busy", first_busy, 1);
    chk("seq2_first_hd", first_hd, 0);
    chk("seq2_first_vd", first_vd, 0);
    chk("seq2_busy_cnt", busy_cnt, 64);
    chk("seq2_hd_cnt", hd_cnt, 48);
    chk("seq2_vd_cnt", vd_cnt, 48);
    chk("seq2_fd_cnt", fd_cnt, 2);
    chk("seq2_fd_first", fd_first, 32);
    chk("seq2_fd_last", fd_last, 64);
    chk("seq2_sd_cnt", sd_cnt, 1);
    chk("seq2_sd_at", sd_at, 64);

    // Stop mid second frame of a five-frame sequence
    set_cfg(8, 2, 4, 1, 5);
    do_start();
    observe(100, 40);
    chk("stop40_fd_cnt", fd_cnt, 2);
    chk("stop40_sd_at", sd_at, 64);
    chk("stop40_busy_cnt", busy_cnt, 64);

    // Stop on the frame-end cycle itself
    do_start();
    observe(60, 31);
    chk("stopend_fd_cnt", fd_cnt, 1);
    chk("stopend_sd_at", sd_at, 32);
    chk("stopend_busy_cnt", busy_cnt, 32);

    // Invalid config: h_blank == h_total
    set_cfg(8, 8, 4, 1, 2);
    do_start();
    observe(6, -1);
    chk("hblank_err_cnt", ce_cnt, 1);
    chk("hblank_err_at0", int'(ce_cnt == 1 && busy_cnt == 0), 1);
    chk("hblank_busy", busy_cnt, 0);

    // frame_num = 0
    set_cfg(8, 2, 4, 1, 0);
    do_start();
`ifdef FSEQ_CONT_EN
    observe(140, 100);
    chk("cont_err", ce_cnt, 0);
    chk("cont_fd_cnt", fd_cnt, 4);
    chk("cont_sd_at", sd_at, 128);
    chk("cont_busy_cnt", busy_cnt, 128);
`else
    observe(6, -1);
    chk("fn0_err_cnt", ce_cnt, 1);
    chk("fn0_busy", busy_cnt, 0);
`endif

    // Asynchronous reset mid-frame, then immediate restart
    set_cfg(8, 2, 4, 1, 2);
    do_start();
    observe(17, -1);
    chk("prerst_busy", int'(busy_o), 1);
    chk("prerst_vd", int'(vd_o), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy_o), 0);
    chk("midrst_hd_vd", int'({hd_o, vd_o}), 0);
    step();
    chk("midrst_fd", int'(frame_done_o), 0);
    rst_n = 1'b1;
    do_start();
    observe(40, -1);
    chk("postrst_first_busy", first_busy, 1);
    chk("postrst_first_hd", first_hd, 0);
    chk("postrst_fd_first", fd_first, 32);
    chk("postrst_fd_cnt", fd_cnt, 1);
    observe(40, -1);
    chk("postrst_sd_cnt", sd_cnt, 1);

    // start held through back-to-back one-frame sequences
    set_cfg(2, 0, 1, 0, 1);
    start_i = 1'b1;
    for (int j = 0; j < 8; j++) begin
      busy_vec[j] = busy_o;
      sd_vec[j]   = seq_done_o;
      step();
    end
    start_i = 1'b0;
    chk("hold_busy_vec", int'(busy_vec), 'h66);
    chk("hold_sd_vec", int'(sd_vec), 'h88);
    observe(6, -1);

    // start+stop together in IDLE starts; config change mid-run ignored
    set_cfg(8, 2, 4, 1, 1);
    stop_i = 1'b1;
    do_start();
    stop_i = 1'b0;
    h_total_i = 16'd16;
    h_blank_i = 16'd0;
    observe(40, -1);
    chk("chg_busy_cnt", busy_cnt, 32);
    chk("chg_fd_first", fd_first, 32);
    chk("chg_hd_cnt", hd_cnt, 24);
    chk("chg_sd_at", sd_at, 32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
